mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single off-chip memory port between instruction fetch (IF) and the data-memory access of the MEM stage.
- The data requester is driven by the MemRead/MemWrite control decode.
- Sequences each transaction as grant → hold request until ack → respond, with round-robin arbitration when both sides request.
- Generates the pipeline stall, and a sticky error if memory never acknowledges.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, maximum cycles BUSY waits for mem_ack_i before aborting; must be ≥1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
if_req_i  in  1  fetch request; held with if_addr_i stable until if_ready_o
if_addr_i  in  ADDR_W  fetch address
if_rdata_o  out  DATA_W  fetched word, valid when if_ready_o
if_ready_o  out  1  one-cycle completion pulse for fetch
d_req_i  in  1  data request (MemRead|MemWrite); held with d_we_i/d_addr_i/d_wdata_i stable until d_ready_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_rdata_o  out  DATA_W  load data, valid when d_ready_o
d_ready_o  out  1  one-cycle completion pulse for data
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory acknowledge; mem_rdata_i valid in the same cycle
mem_rdata_i  in  DATA_W  memory read data
stall_o  out  1  pipeline stall
err_o  out  1  sticky timeout flag

Behaviour:
- Clocking: one clock, clk_i. rst_i is synchronous and active-high; all state updates on the rising edge of clk_i.
- Reset (rst_i=1 at an edge, including mid-transaction):
  - state→IDLE; last_owner→IF, so data wins the first tie.
  - All mem_* outputs, ready pulses, rdata outputs, the timeout counter and err_o → 0.
  - An in-flight transaction is dropped, and a late mem_ack_i is ignored.
- State IDLE (mem_req_o=0):
  - Only d_req_i → grant D. Only if_req_i → grant IF.
  - Both → grant the side that is not last_owner.
  - On grant: latch owner, address, we (0 for IF) and wdata into the mem_* registers; go to BUSY. mem_req_o=1 from the next cycle.
  - No request → stay in IDLE.
- State BUSY:
  - mem_req_o=1, with mem_* stable.
  - Counter increments each cycle.
  - mem_ack_i=1 → capture mem_rdata_i into the owner's rdata output (0 for a store); go to RESP.
  - If the counter reaches TIMEOUT with no ack → set err_o=1, set rdata=0, go to RESP.
  - Ack has priority over timeout when both occur in the same cycle, and err_o is then not set.
- State RESP:
  - Owner's ready=1 for exactly this cycle; mem_req_o=0; last_owner←owner; counter cleared; go to IDLE.
- mem_ack_i outside BUSY is ignored.
- Latency: request first seen in IDLE at cycle 0, ack at cycle k (k≥1) → ready at k+1, IDLE at k+2. Minimum 3 cycles per transaction.
- The non-owner's request stays pending and is not latched.
- rdata outputs hold their value until overwritten by the next completion of the same side.
- stall_o is combinational: (d_req_i & ~d_ready_o) | (if_req_i & ~if_ready_o).
- err_o is cleared only by rst_i.
- Requesters must present a new or dropped request in the cycle after ready. A request still high in IDLE is treated as new.

Test Plan:
- Single load: d_req_i=1, d_we_i=0, d_addr_i=0x100; ack at cycle 4 with rdata 0xDEADBEEF → mem_req_o high cycles 1–4, mem_addr_o=0x100, d_ready_o pulse at cycle 5, d_rdata_o=0xDEADBEEF, stall_o=1 during cycles 0–4 only.
- Store: d_we_i=1, d_addr_i=0x20, d_wdata_i=0x12345678, ack at cycle 2 → mem_we_o=1, mem_wdata_o=0x12345678, d_ready_o at cycle 3, d_rdata_o=0.
- Contention after reset: if_req_i and d_req_i both high at cycle 0 and held, immediate acks → D granted first; IF granted next with mem_we_o=0 and if_addr_i on mem_addr_o.
- Round-robin: both requests held continuously for 4 transactions → grant order D, IF, D, IF, with exactly one ready pulse per transaction.
- Timeout: TIMEOUT=4, no ack → err_o=1 after 4 BUSY cycles, ready pulses with rdata=0, err_o stays 1 across later good transactions.
- Reset mid-BUSY: assert rst_i during BUSY, then ack one cycle later → no ready pulse, mem_req_o=0, err_o=0, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one off-chip memory port between instruction fetch and MEM-stage data
// accesses: grant, hold the request until ack or timeout, then pulse ready.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  // Counter only has to represent 0..TIMEOUT-1; the final BUSY cycle is
  // detected when it already holds TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              last_owner_reg, last_owner_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
  logic              err_reg, err_next;
  logic              grant_d;
  logic [DATA_W-1:0] resp_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IF;
      last_owner_reg <= OWN_IF;
      cnt_reg        <= '0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      cnt_reg        <= cnt_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      if_rdata_reg   <= if_rdata_next;
      d_rdata_reg    <= d_rdata_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    cnt_next        = cnt_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    if_rdata_next   = if_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    err_next        = err_reg;
    grant_d         = 1'b0;
    resp_data       = '0;

    case (state_reg)
      IDLE: begin
        if (d_req_i || if_req_i) begin
          // On a tie the side that did not own the previous transaction wins.
          grant_d        = d_req_i && (!if_req_i || (last_owner_reg == OWN_IF));
          owner_next     = grant_d ? OWN_D : OWN_IF;
          mem_we_next    = grant_d ? d_we_i : 1'b0;
          mem_addr_next  = grant_d ? d_addr_i : if_addr_i;
          mem_wdata_next = grant_d ? d_wdata_i : '0;
          cnt_next       = '0;
          state_next     = BUSY;
        end
      end

      BUSY: begin
        if (mem_ack_i || (cnt_reg == CNT_LAST)) begin
          // Stores and timeouts both return zero; ack beats timeout.
          resp_data = (mem_ack_i && !mem_we_reg) ? mem_rdata_i : '0;
          if (!mem_ack_i) begin
            err_next = 1'b1;
          end
          if (owner_reg == OWN_D) begin
            d_rdata_next = resp_data;
          end else begin
            if_rdata_next = resp_data;
          end
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RESP: begin
        last_owner_next = owner_reg;
        cnt_next        = '0;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_req_o   = (state_reg == BUSY);
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;

  assign if_ready_o  = (state_reg == RESP) && (owner_reg == OWN_IF);
  assign d_ready_o   = (state_reg == RESP) && (owner_reg == OWN_D);
  assign if_rdata_o  = if_rdata_reg;
  assign d_rdata_o   = d_rdata_reg;
  assign err_o       = err_reg;

  assign stall_o = (d_req_i && !d_ready_o) || (if_req_i && !if_ready_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, hand-written corner sequences and
// random traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ready_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_ready_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: a transaction granted at cycle m_s occupies the port from
  // m_s+1 until it is acked or until cycle m_s+TO; it completes at m_done.
  bit          m_active;
  int          m_s;
  int          m_done;
  bit          m_side;   // 1 = data, 0 = fetch
  bit          m_last;
  bit          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_if_rdata;
  logic [DW-1:0] m_d_rdata;
  bit          m_err;

  bit obs_if_ready, obs_d_ready, obs_req, obs_err;
  logic [DW-1:0] obs_d_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_s        = 0;
    m_done     = -1;
    m_side     = 1'b0;
    m_last     = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    m_err      = 1'b0;
  endtask

  // Inputs for the current cycle are already driven; check, update model, advance.
  task automatic step();
    bit e_req, e_ir, e_dr, e_stall;
    #1;
    e_req   = m_active && (m_done < 0) && (cyc > m_s);
    e_ir    = m_active && (cyc == m_done) && !m_side;
    e_dr    = m_active && (cyc == m_done) && m_side;
    e_stall = (d_req_i && !e_dr) || (if_req_i && !e_ir);
    check("mem_req", 64'(mem_req_o), 64'(e_req));
    if (e_req) begin
      check("mem_we", 64'(mem_we_o), 64'(m_we));
      check("mem_addr", 64'(mem_addr_o), 64'(m_addr));
      if (m_we) check("mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
    end
    check("if_ready", 64'(if_ready_o), 64'(e_ir));
    check("d_ready", 64'(d_ready_o), 64'(e_dr));
    check("if_rdata", 64'(if_rdata_o), 64'(m_if_rdata));
    check("d_rdata", 64'(d_rdata_o), 64'(m_d_rdata));
    check("stall", 64'(stall_o), 64'(e_stall));
    check("err", 64'(err_o), 64'(m_err));
    obs_if_ready = if_ready_o;
    obs_d_ready  = d_ready_o;
    obs_req      = mem_req_o;
    obs_err      = err_o;
    obs_d_rdata  = d_rdata_o;

    if (rst_i) begin
      model_reset();
    end else if (m_active && cyc == m_done) begin
      m_last   = m_side;
      m_active = 1'b0;
      m_done   = -1;
    end else if (e_req) begin
      if (mem_ack_i) begin
        m_done = cyc + 1;
        if (m_side) m_d_rdata = m_we ? '0 : mem_rdata_i;
        else        m_if_rdata = mem_rdata_i;
      end else if (cyc - m_s == TO) begin
        m_done = cyc + 1;
        m_err  = 1'b1;
        if (m_side) m_d_rdata = '0;
        else        m_if_rdata = '0;
      end
    end else if (!m_active && (d_req_i || if_req_i)) begin
      m_side   = d_req_i && (!if_req_i || !m_last);
      m_active = 1'b1;
      m_s      = cyc;
      m_done   = -1;
      m_we     = m_side ? d_we_i : 1'b0;
      m_addr   = m_side ? d_addr_i : if_addr_i;
      m_wdata  = d_wdata_i;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0;
    d_addr_i = '0; d_wdata_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    cyc++;
    #1;
    check("rst_mem_req", 64'(mem_req_o), 64'(0));
    check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    check("rst_d_ready", 64'(d_ready_o), 64'(0));
    check("rst_d_rdata", 64'(d_rdata_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
  endtask

  typedef struct {
    bit            d_req;
    bit            d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    bit            ack;
    logic [DW-1:0] rdata;
    bit            e_req;
    bit            e_dready;
    bit            e_stall;
    logic [DW-1:0] e_drdata;
  } vec_t;

  vec_t vecs[12];
  int   order[$];
  int   hit;

  initial begin
    // Single load (ack at cycle 4), idle gap, then a store (ack at cycle 2).
    vecs[0]  = '{1, 0, 32'h100, 32'h0, 0, 32'h0,        0, 0, 1, 32'h0};
    vecs[1]  = '{1, 0, 32'h100, 32'h0, 0, 32'h0,        1, 0, 1, 32'h0};
    vecs[2]  = '{1, 0, 32'h100, 32'h0, 0, 32'h0,        1, 0, 1, 32'h0};
    vecs[3]  = '{1, 0, 32'h100, 32'h0, 0, 32'h0,        1, 0, 1, 32'h0};
    vecs[4]  = '{1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1, 0, 1, 32'h0};
    vecs[5]  = '{1, 0, 32'h100, 32'h0, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF};
    vecs[6]  = '{0, 0, 32'h0,   32'h0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF};
    vecs[7]  = '{1, 1, 32'h20, 32'h12345678, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF};
    vecs[8]  = '{1, 1, 32'h20, 32'h12345678, 0, 32'h0,        1, 0, 1, 32'hDEADBEEF};
    vecs[9]  = '{1, 1, 32'h20, 32'h12345678, 1, 32'hAAAA5555, 1, 0, 1, 32'hDEADBEEF};
    vecs[10] = '{1, 1, 32'h20, 32'h12345678, 0, 32'h0,        0, 1, 0, 32'h0};
    vecs[11] = '{0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      d_req_i = vecs[i].d_req; d_we_i = vecs[i].d_we;
      d_addr_i = vecs[i].d_addr; d_wdata_i = vecs[i].d_wdata;
      mem_ack_i = vecs[i].ack; mem_rdata_i = vecs[i].rdata;
      #1;
      check("tbl_req", 64'(mem_req_o), 64'(vecs[i].e_req));
      if (vecs[i].e_req) begin
        check("tbl_addr", 64'(mem_addr_o), 64'(vecs[i].d_addr));
        check("tbl_we", 64'(mem_we_o), 64'(vecs[i].d_we));
        if (vecs[i].d_we) check("tbl_wdata", 64'(mem_wdata_o), 64'(vecs[i].d_wdata));
      end
      check("tbl_dready", 64'(d_ready_o), 64'(vecs[i].e_dready));
      check("tbl_stall", 64'(stall_o), 64'(vecs[i].e_stall));
      check("tbl_drdata", 64'(d_rdata_o), 64'(vecs[i].e_drdata));
      step();
    end

    // Contention and round-robin: both held, ack held high.
    do_reset();
    if_req_i = 1; if_addr_i = 32'h1000; d_req_i = 1; d_addr_i = 32'h2000; d_we_i = 0;
    mem_ack_i = 1;
    for (int i = 0; i < 30 && order.size() < 4; i++) begin
      mem_rdata_i = $urandom;
      step();
      if (obs_d_ready) begin order.push_back(1); d_addr_i += 8; end
      if (obs_if_ready) begin order.push_back(0); if_addr_i += 4; end
    end
    check("rr_count", 64'(order.size()), 64'(4));
    for (int i = 0; i < order.size(); i++)
      check("rr_order", 64'(order[i]), 64'((i % 2 == 0) ? 1 : 0));
    clear_inputs();
    step();

    // Timeout: good load first so the zeroed rdata is visible, then no ack.
    do_reset();
    d_req_i = 1; d_addr_i = 32'h40; step();
    mem_ack_i = 1; mem_rdata_i = 32'h5A5A0001; step();
    mem_ack_i = 0; step();
    d_req_i = 0; step();
    d_req_i = 1; d_addr_i = 32'h44;
    hit = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_d_ready) begin hit = i; break; end
    end
    check("to_ready_cycle", 64'(hit), 64'(TO + 1));
    check("to_err", 64'(obs_err), 64'(1));
    check("to_rdata", 64'(obs_d_rdata), 64'(0));
    d_req_i = 0; if_req_i = 1; if_addr_i = 32'h80; mem_ack_i = 1; mem_rdata_i = 32'h77;
    step(); step(); step();
    if_req_i = 0; mem_ack_i = 0; step();
    check("to_err_sticky", 64'(obs_err), 64'(1));

    // Reset during BUSY, followed by a late ack.
    d_req_i = 1; d_addr_i = 32'h300; step(); step();
    rst_i = 1; step();
    rst_i = 0; mem_ack_i = 1; d_req_i = 0; step();
    check("rb_req", 64'(obs_req), 64'(0));
    check("rb_ready", 64'(obs_d_ready), 64'(0));
    check("rb_err", 64'(obs_err), 64'(0));
    mem_ack_i = 0; step();
    check("rb_ready2", 64'(obs_d_ready), 64'(0));

    // Random traffic against the model.
    do_reset();
    obs_if_ready = 0; obs_d_ready = 0;
    for (int i = 0; i < 900; i++) begin
      if (obs_d_ready || !d_req_i) begin
        d_req_i = obs_d_ready ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        d_we_i = $urandom_range(0, 1); d_addr_i = $urandom; d_wdata_i = $urandom;
      end
      if (obs_if_ready || !if_req_i) begin
        if_req_i = obs_if_ready ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        if_addr_i = $urandom;
      end
      mem_ack_i = ($urandom_range(0, 99) < ((i < 450) ? 45 : 12));
      mem_rdata_i = $urandom;
      rst_i = ($urandom_range(0, 149) == 0);
      step();
    end
    rst_i = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
